// File: rtl/crc32_pkg.sv
// crc32_pkg: shared constants and FSM state type for the PNG CRC-32
// (ISO-HDLC) generator/checker pair.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_RVS = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ACTV,
    BYTE,
    WCRC,
    CMP
  } crc32_state_t;

endpackage

// File: rtl/crc32_byte_upd.sv
// crc32_byte_upd: combinational reflected CRC-32 update by one byte.
// Ports:
//   cur  - current CRC register (pre-xorout)
//   data - byte to fold in, consumed LSB-first
//   nxt  - updated CRC register
module crc32_byte_upd
  import crc32_pkg::*;
(
  input  logic [31:0] cur,
  input  logic [7:0]  data,
  output logic [31:0] nxt
);

  logic [31:0] c;

  always_comb begin
    c = cur ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_RVS) : (c >> 1);
    end
    nxt = c;
  end

endmodule

// File: rtl/crc32_chk.sv
// crc32_chk: receive-side CRC-32 checker for PNG chunks. Chunk type and
// data arrive as big-endian 32-bit words, followed by the received CRC word.
// One byte is folded per cycle; done_o pulses with pass_o after the check.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start_i             - begin (or restart) a chunk
//   val_i/rdy_o/dat_i   - word handshake, first byte in [31:24]
//   lst_i, nbyte_i      - last data word marker and its valid byte count
//   done_o, pass_o      - check-complete pulse and held result
//   crc_o               - running CRC with final xor applied
//   chk_cnt_o/err_cnt_o - saturating statistics (CRC32_CHK_STAT_EN only)
// Optional feature macro: CRC32_CHK_STAT_EN
module crc32_chk
  import crc32_pkg::*;
#(
  parameter int DATA_WD = 32
`ifdef CRC32_CHK_STAT_EN
  ,
  parameter int STAT_WD = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               val_i,
  output logic               rdy_o,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic               lst_i,
  input  logic [1:0]         nbyte_i,
  output logic               done_o,
  output logic               pass_o,
  output logic [31:0]        crc_o
`ifdef CRC32_CHK_STAT_EN
  ,
  output logic [STAT_WD-1:0] chk_cnt_o,
  output logic [STAT_WD-1:0] err_cnt_o
`endif
);

  crc32_state_t       state;
  logic [31:0]        crc_q;
  logic [31:0]        crc_nxt;
  logic [DATA_WD-1:0] buf_q;
  logic [1:0]         cnt_q;
  logic [1:0]         ld_cnt;
  logic               last_q;
  logic [7:0]         upd_byte;

  assign rdy_o = (state == ACTV) || (state == WCRC);
  assign crc_o = crc_q ^ CRC32_XOROUT;

  // Bytes still to process after the one folded on accept. nbyte_i-1 in
  // 2-bit arithmetic maps 0 (=4 bytes) to 3 naturally.
  assign ld_cnt = lst_i ? (nbyte_i - 2'd1) : 2'd3;

  // Accept cycle takes the top byte straight from the bus; BYTE cycles take
  // it from the left-shifted buffer.
  assign upd_byte = (state == BYTE) ? buf_q[DATA_WD-1 -: 8] : dat_i[DATA_WD-1 -: 8];

  crc32_byte_upd u_upd (
    .cur  (crc_q),
    .data (upd_byte),
    .nxt  (crc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      crc_q  <= CRC32_INIT;
      buf_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        state  <= ACTV;
        crc_q  <= CRC32_INIT;
        pass_o <= 1'b0;
      end else begin
        case (state)
          ACTV: begin
            if (val_i) begin
              crc_q  <= crc_nxt;
              buf_q  <= {dat_i[DATA_WD-9:0], 8'h00};
              cnt_q  <= ld_cnt;
              last_q <= lst_i;
              if (ld_cnt != 2'd0) state <= BYTE;
              else if (lst_i)     state <= WCRC;
            end
          end
          BYTE: begin
            crc_q <= crc_nxt;
            buf_q <= {buf_q[DATA_WD-9:0], 8'h00};
            cnt_q <= cnt_q - 2'd1;
            if (cnt_q == 2'd1) state <= last_q ? WCRC : ACTV;
          end
          WCRC: begin
            if (val_i) begin
              done_o <= 1'b1;
              pass_o <= (dat_i == crc_o);
              state  <= CMP;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CRC32_CHK_STAT_EN
  // Counted on the CRC-word transfer so the values line up with done_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_cnt_o <= '0;
      err_cnt_o <= '0;
    end else if (!start_i && state == WCRC && val_i) begin
      if (chk_cnt_o != '1) chk_cnt_o <= chk_cnt_o + STAT_WD'(1);
      if (dat_i != crc_o && err_cnt_o != '1) err_cnt_o <= err_cnt_o + STAT_WD'(1);
    end
  end
`endif

endmodule

// File: tb/tb_crc32_chk.sv
// tb_crc32_chk: self-checking bench for crc32_chk. Expected results are
// queued when a CRC word is driven and compared when done_o appears.
module tb_crc32_chk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] crc;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        val_i;
  logic        rdy_o;
  logic [31:0] dat_i;
  logic        lst_i;
  logic [1:0]  nbyte_i;
  logic        done_o;
  logic        pass_o;
  logic [31:0] crc_o;
`ifdef CRC32_CHK_STAT_EN
  logic [15:0] chk_cnt_o;
  logic [15:0] err_cnt_o;
  int          exp_chk = 0;
  int          exp_err = 0;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   n_push = 0;
  exp_t sb_q[$];

  crc32_chk dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .val_i     (val_i),
    .rdy_o     (rdy_o),
    .dat_i     (dat_i),
    .lst_i     (lst_i),
    .nbyte_i   (nbyte_i),
    .done_o    (done_o),
    .pass_o    (pass_o),
    .crc_o     (crc_o)
`ifdef CRC32_CHK_STAT_EN
    ,
    .chk_cnt_o (chk_cnt_o),
    .err_cnt_o (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_model(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Scoreboard side: every done_o pops one expectation.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("crc_o", crc_o, e.crc);
        check("pass_o", {31'd0, pass_o}, {31'd0, e.pass});
`ifdef CRC32_CHK_STAT_EN
        exp_chk++;
        if (!e.pass) exp_err++;
        check("chk_cnt", {16'd0, chk_cnt_o}, 32'(exp_chk));
        check("err_cnt", {16'd0, err_cnt_o}, 32'(exp_err));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    val_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called at a negedge; holds val_i until rdy_o is seen, returns the number
  // of cycles spent waiting and ends at the negedge after the transfer.
  task automatic xfer(input logic [31:0] d, input logic l, input logic [1:0] nb,
                      output int waits);
    val_i = 1'b1; dat_i = d; lst_i = l; nbyte_i = nb; waits = 0;
    while (!rdy_o && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (!rdy_o) check("xfer_timeout", 32'd0, 32'd1);
    else        @(negedge clk);
    val_i = 1'b0; lst_i = 1'b0;
  endtask

  task automatic send_chunk(input bq_t b, input logic [31:0] rx_crc,
                            input logic [31:0] exp_crc, input logic exp_pass,
                            input int gap, input bit do_st);
    int n, nw, w, rem;
    logic [31:0] word;
    logic [1:0]  nb;
    n = b.size(); nw = (n + 3) / 4; rem = 0;
    if (do_st) do_start();
    for (int k = 0; k < nw; k++) begin
      word = '0;
      for (int j = 0; j < 4; j++)
        if (k * 4 + j < n) word[31 - 8 * j -: 8] = b[k * 4 + j];
      nb = (k == nw - 1) ? 2'(n % 4) : 2'd0;
      xfer(word, k == nw - 1, nb, w);
      if (k > 0) check("rdy_low_word", 32'(w), 32'(rem > gap ? rem - gap : 0));
      rem = (k == nw - 1) ? (n - 4 * k - 1) : 3;
      idle(gap);
    end
    sb_q.push_back('{crc: exp_crc, pass: exp_pass});
    n_push++;
    xfer(rx_crc, 1'b0, 2'd0, w);
    check("rdy_low_crc", 32'(w), 32'(rem > gap ? rem - gap : 0));
    check("done_latency", {31'd0, done_o}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    bq_t iend, s9, rb;
    int  d0, w;
    logic [31:0] c;
    iend = '{8'h49, 8'h45, 8'h4E, 8'h44};
    s9   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    rst = 1'b1; start_i = 1'b0; val_i = 1'b0; dat_i = '0; lst_i = 1'b0; nbyte_i = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy", {31'd0, rdy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_pass", {31'd0, pass_o}, 32'd0);
    check("rst_crc", crc_o, 32'h0000_0000);
`ifdef CRC32_CHK_STAT_EN
    check("rst_chk_cnt", {16'd0, chk_cnt_o}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt_o}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Start with val_i high in IDLE: word must be ignored
    val_i = 1'b1; dat_i = 32'hDEAD_BEEF;
    do_start();
    val_i = 1'b0;
    check("idle_start_crc", crc_o, 32'h0000_0000);

    // IEND
    send_chunk(iend, 32'hAE42_6082, 32'hAE42_6082, 1'b1, 0, 1'b1);
    // "123456789", back-to-back words
    send_chunk(s9, 32'hCBF4_3926, 32'hCBF4_3926, 1'b1, 0, 1'b1);
    // Corrupt CRC
    send_chunk(iend, 32'hAE42_6083, 32'hAE42_6082, 1'b0, 0, 1'b1);
    check("pass_held", {31'd0, pass_o}, 32'd0);

    // Abort during BYTE, then IEND
    do_start();
    xfer(32'h3132_3334, 1'b0, 2'd0, w);
    d0 = done_cnt;
    do_start();
    send_chunk(iend, 32'hAE42_6082, 32'hAE42_6082, 1'b1, 0, 1'b0);
    idle(4);
    check("abort_done_count", 32'(done_cnt - d0), 32'd1);

    // Gaps between words give the same result
    send_chunk(s9, 32'hCBF4_3926, 32'hCBF4_3926, 1'b1, 2, 1'b1);
    send_chunk(s9, 32'hCBF4_3926, 32'hCBF4_3926, 1'b1, 5, 1'b1);

    // Random chunks against the bench model, last one corrupted
    for (int r = 0; r < 5; r++) begin
      rb = {};
      for (int i = 0; i < int'($urandom_range(1, 16)); i++) rb.push_back(8'($urandom_range(0, 255)));
      c = crc_model(rb);
      if (r == 4) send_chunk(rb, c ^ 32'h0001_0000, c, 1'b0, r % 3, 1'b1);
      else        send_chunk(rb, c, c, 1'b1, r % 3, 1'b1);
    end

    // Reset while waiting for the CRC word
    do_start();
    xfer(32'h4945_4E44, 1'b1, 2'd0, w);
    for (int i = 0; i < 16 && !rdy_o; i++) @(negedge clk);
    check("reached_wcrc", {31'd0, rdy_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy", {31'd0, rdy_o}, 32'd0);
    check("mid_rst_done", {31'd0, done_o}, 32'd0);
    check("mid_rst_pass", {31'd0, pass_o}, 32'd0);
    check("mid_rst_crc", crc_o, 32'h0000_0000);
`ifdef CRC32_CHK_STAT_EN
    exp_chk = 0; exp_err = 0;
    check("mid_rst_chk_cnt", {16'd0, chk_cnt_o}, 32'd0);
`endif
    rst = 1'b0;
    idle(2);
    send_chunk(iend, 32'hAE42_6082, 32'hAE42_6082, 1'b1, 0, 1'b1);

    idle(4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("done_total", 32'(done_cnt), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crc32_chk.md
Name: crc32_chk

Overview:
- Receive-side CRC-32 checker for PNG chunk streams, the counterpart of the CRC generator on the encode path.
- Consumes chunk type and data as 32-bit big-endian words, then the chunk's received CRC word.
- Computes the ISO-HDLC/PNG CRC (reflected poly 0x04C11DB7, init 0xFFFFFFFF, xorout 0xFFFFFFFF) one byte per cycle and reports pass/fail.
- Sits behind the chunk parser in the PNG decode path.

Parameters:
- DATA_WD, 32, input word width (fixed; bytes per word = 4)
- STAT_WD, 16, width of statistic counters (used only with CRC32_CHK_STAT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  begin new chunk; re-initialises CRC
- val_i  in  1  dat_i valid
- rdy_o  out  1  checker accepts a word this cycle (transfer = val_i & rdy_o)
- dat_i  in  32  data word; first byte in [31:24]
- lst_i  in  1  qualifies the final data word of the chunk
- nbyte_i  in  2  valid bytes in the last word (0 = 4, 1..3 = that many, MSB-aligned); read only with lst_i
- done_o  out  1  one-cycle pulse: check complete
- pass_o  out  1  result of last check; held until next start_i
- crc_o  out  32  computed CRC (final xor applied), current running value
- chk_cnt_o  out  STAT_WD  chunks checked (macro only)
- err_cnt_o  out  STAT_WD  chunks failed (macro only)

Behaviour:
- Reset: state IDLE; rdy_o=0, done_o=0, pass_o=0; CRC register=0xFFFFFFFF so crc_o=0x00000000; counters 0.
- Byte order: bytes processed [31:24], [23:16], [15:8], [7:0]; each byte LSB-first (reflected).
- rdy_o is combinational: 1 only in ACTV or WCRC.
- FSM states:
  - IDLE: start_i -> ACTV; CRC register <= 0xFFFFFFFF.
  - ACTV: on transfer, byte [31:24] is folded into the CRC in the same cycle. The remaining valid-byte count (3, or nbyte_i-1 if lst_i) is loaded into a 2-bit counter. Next state:
    - count>0 -> BYTE
    - else lst_i -> WCRC
    - else ACTV
  - BYTE: one byte per cycle from the buffered word; counter decrements. When the counter reaches 1, exit to WCRC if the word was last, else ACTV.
  - WCRC: on transfer, dat_i is the received CRC (PNG big-endian). Compare against crc_o -> CMP.
  - CMP: done_o=1 and pass_o=(match) are both registered, visible the cycle after the CRC transfer. -> IDLE.
- Throughput: full word = 4 cycles (1 accept + 3 BYTE). Last word with nbyte_i=1 takes no BYTE cycles.
- Latency: CRC-word transfer at cycle t -> done_o/pass_o at t+1.
- start_i in any non-IDLE state: abort the current chunk, reinitialise the CRC, go to ACTV. No done_o; pass_o cleared. start_i has priority over a simultaneous transfer; that word is dropped.
- start_i in IDLE together with val_i: the word is ignored (rdy_o=0).
- val_i while rdy_o=0: no effect; the upstream holds the data.
- start_i asserted in CMP: done_o still pulses that cycle, then ACTV.
- rst mid-chunk: immediate return to reset values; partial CRC discarded.

Optional Feature:
- Macro CRC32_CHK_STAT_EN.
- Defined: chk_cnt_o increments on every done_o; err_cnt_o increments on done_o with pass_o=0. Both saturate at all-ones and clear only on rst.
- Undefined: neither port nor counter exists; the module has no extra logic.

Decomposition:
- Package crc32_pkg holds:
  - CRC32_POLY_RVS=0xEDB88320, CRC32_INIT=0xFFFFFFFF, CRC32_XOROUT=0xFFFFFFFF
  - FSM state typedef (IDLE, ACTV, BYTE, WCRC, CMP)
- Sub-module crc32_byte_upd: purely combinational; 32-bit cur + 8-bit byte -> 32-bit nxt, reflected update. Reusable by the generator.

Test Plan:
- IEND chunk: start; word 0x49454E44 with lst_i=1, nbyte_i=0; CRC word 0xAE426082 -> crc_o=0xAE426082; done_o pulses 1 cycle after the CRC transfer; pass_o=1.
- Check string "123456789": words 0x31323334, 0x35363738, then 0x39000000 with lst_i=1, nbyte_i=1; CRC word 0xCBF43926 -> pass_o=1; rdy_o low exactly 3 cycles after each of the first two words and 0 cycles after the last.
- Corrupt CRC: IEND with CRC word 0xAE426083 -> done_o=1, pass_o=0; with the macro, err_cnt_o=1 and chk_cnt_o=1.
- Abort: start, send 0x31323334, assert start_i during BYTE, then run the IEND sequence -> pass_o=1, exactly one done_o.
- Backpressure/reset: val_i held high continuously -> transfers only when rdy_o=1 and the result is unchanged. Assert rst in WCRC -> next cycle rdy_o=0, done_o=0, pass_o=0, crc_o=0x00000000.
